// File: rtl/ram_pkg.sv
// Shared types and boot image for the unified program/data RAM.
// Imported by the init sequencer and the RAM top level.
package ram_pkg;

    typedef enum logic [1:0] {
        NO_CHANGE   = 2'd0,
        READ_FIRST  = 2'd1,
        WRITE_FIRST = 2'd2
    } write_mode_e;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int BOOT_AW  = 4;
    localparam int BOOT_LEN = 2 ** BOOT_AW;

    // Processor boot program, word i lands at address i.
    localparam logic [7:0] BOOT_IMAGE [BOOT_LEN] = '{
        8'h3E, 8'h00, 8'h06, 8'h10,
        8'h80, 8'h3D, 8'hC2, 8'h04,
        8'h00, 8'h32, 8'h1F, 8'h00,
        8'h76, 8'h00, 8'hFF, 8'hA5
    };

endpackage

// File: rtl/ram_sp_boot_if.sv
// Memory port between the CPU core (master) and the RAM (slave).
// busy tells the core to hold off during the init sweep.
interface ram_sp_boot_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          req;
    logic          wren;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic [DW-1:0] q;
    logic          q_valid;
    logic          busy;
    logic          addr_err;

    modport master (
        output req, wren, address, data,
        input  q, q_valid, busy, addr_err
    );

    modport slave (
        input  req, wren, address, data,
        output q, q_valid, busy, addr_err
    );
endinterface

// File: rtl/ram_init_seq.sv
// Post-reset init sweep: writes every word once, then reports ready.
// Contents come from the boot image or the fill value.
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int            DW         = 8,
    parameter int            AW         = 8,
    parameter int            DEPTH      = 256,
    parameter int            INIT_MODE  = 1,
    parameter logic [DW-1:0] FILL_VALUE = '0
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic          busy,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic [DW-1:0] init_data
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e        state;
    state_e        state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;
    logic [31:0]   idx;

    // State and sweep counter; reset restarts the sweep at word 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // One word per cycle; the edge writing the last word enters READY.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_we   = 1'b0;
        unique case (state)
            INIT: begin
                init_we = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end
            end
            READY: begin
            end
            default: state_nxt = INIT;
        endcase
    end

    // Word content for the current sweep address.
    always_comb begin
        idx       = 32'(cnt);
        init_data = FILL_VALUE;
        if (INIT_MODE == 1 && idx < 32'(BOOT_LEN)) begin
            init_data = DW'(BOOT_IMAGE[idx[BOOT_AW-1:0]]);
        end
    end

    assign init_addr = cnt;
    assign busy      = (state == INIT);

endmodule

// File: rtl/ram_sp_boot.sv
// Single-port synchronous RAM with post-reset init sweep.
// Init port and user port share one write path into the array.
module ram_sp_boot
    import ram_pkg::*;
#(
    parameter int            DW         = 8,
    parameter int            AW         = 8,
    parameter int            DEPTH      = 256,
    parameter int            INIT_MODE  = 1,
    parameter logic [DW-1:0] FILL_VALUE = '0,
    parameter int            WRITE_MODE = 0
) (
    input  logic          clock,
    input  logic          reset_n,
    ram_sp_boot_if.slave  bus
);
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam write_mode_e WM = write_mode_e'(WRITE_MODE);

    logic          busy;
    logic          init_we;
    logic [AW-1:0] init_addr;
    logic [DW-1:0] init_data;

    logic [DW-1:0] mem [DEPTH];

    logic          acc;
    logic          in_range;
    logic          we;
    logic [MW-1:0] ridx;
    logic [MW-1:0] widx;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] q_r;
    logic          qv_r;
    logic          ae_r;

    ram_init_seq #(
        .DW         (DW),
        .AW         (AW),
        .DEPTH      (DEPTH),
        .INIT_MODE  (INIT_MODE),
        .FILL_VALUE (FILL_VALUE)
    ) u_seq (
        .clock     (clock),
        .reset_n   (reset_n),
        .busy      (busy),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    assign acc      = bus.req & ~busy;
    assign in_range = 32'(bus.address) < 32'(DEPTH);
    assign ridx     = bus.address[MW-1:0];
    assign we       = init_we | (acc & bus.wren & in_range);
    assign widx     = init_we ? init_addr[MW-1:0] : ridx;
    assign wdata    = init_we ? init_data : bus.data;
    assign rd_word  = in_range ? mem[ridx] : '0;

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    // Registered read data and per-access status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_r  <= '0;
            qv_r <= 1'b0;
            ae_r <= 1'b0;
        end else begin
            qv_r <= 1'b0;
            ae_r <= 1'b0;
            if (acc) begin
                ae_r <= ~in_range;
                if (!bus.wren) begin
                    q_r  <= rd_word;
                    qv_r <= 1'b1;
                end else if (WM == READ_FIRST) begin
                    q_r  <= rd_word;
                    qv_r <= 1'b1;
                end else if (WM == WRITE_FIRST) begin
                    q_r  <= in_range ? bus.data : '0;
                    qv_r <= 1'b1;
                end
            end
        end
    end

    assign bus.q        = q_r;
    assign bus.q_valid  = qv_r;
    assign bus.addr_err = ae_r;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_ram_sp_boot.sv
// Bench for ram_sp_boot: five configurations driven in lockstep
// and compared each cycle against an array-based reference model.
module tb_ram_sp_boot;
    import ram_pkg::*;

    localparam int N = 5;
    localparam int DEP [N] = '{32, 32, 32, 200, 1};
    localparam int WMD [N] = '{0, 1, 2, 0, 0};
    localparam int IMD [N] = '{1, 1, 1, 0, 1};
    localparam logic [7:0] FV [N] = '{8'h00, 8'hC3, 8'h00, 8'h5A, 8'h00};

    logic       clock;
    logic       reset_n;
    logic       req;
    logic       wren;
    logic [7:0] address;
    logic [7:0] data;

    logic [7:0] q_o    [N];
    logic       qv_o   [N];
    logic       ae_o   [N];
    logic       busy_o [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        ram_sp_boot_if #(.DW(8), .AW(8)) bus ();
        assign bus.req     = req;
        assign bus.wren    = wren;
        assign bus.address = address;
        assign bus.data    = data;
        assign q_o[g]      = bus.q;
        assign qv_o[g]     = bus.q_valid;
        assign ae_o[g]     = bus.addr_err;
        assign busy_o[g]   = bus.busy;
        ram_sp_boot #(
            .DW         (8),
            .AW         (8),
            .DEPTH      (DEP[g]),
            .INIT_MODE  (IMD[g]),
            .FILL_VALUE (FV[g]),
            .WRITE_MODE (WMD[g])
        ) u_dut (
            .clock   (clock),
            .reset_n (reset_n),
            .bus     (bus.slave)
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int pass  = 0;

    // Reference model: memory image, init progress and expected outputs.
    logic [7:0] mm  [N][256];
    int         cyc [N];
    logic [7:0] eq  [N];
    logic       eqv [N];
    logic       eae [N];
    logic       qk  [N];

    function automatic logic [7:0] init_val(int k, int i);
        if (IMD[k] == 1 && i < BOOT_LEN) return BOOT_IMAGE[i];
        return FV[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            cyc[k] = 0;
            eq[k]  = 8'h00;
            eqv[k] = 1'b0;
            eae[k] = 1'b0;
            qk[k]  = 1'b1;
        end
    endtask

    task automatic model_edge();
        bit inr;
        for (int k = 0; k < N; k++) begin
            eqv[k] = 1'b0;
            eae[k] = 1'b0;
            if (cyc[k] < DEP[k]) begin
                mm[k][cyc[k]] = init_val(k, cyc[k]);
                cyc[k]++;
            end else if (req) begin
                inr    = int'(address) < DEP[k];
                eae[k] = !inr;
                if (!wren) begin
                    eq[k]  = inr ? mm[k][address] : 8'h00;
                    eqv[k] = 1'b1;
                    qk[k]  = 1'b1;
                end else begin
                    if (WMD[k] != 0) begin
                        eqv[k] = 1'b1;
                        qk[k]  = inr;
                        if (WMD[k] == 1) eq[k] = mm[k][address];
                        else             eq[k] = data;
                    end
                    if (inr) mm[k][address] = data;
                end
            end
        end
    endtask

    // Apply one cycle of stimulus, advance the model, sample after the edge.
    task automatic drive(bit r, bit w, logic [7:0] a, logic [7:0] d);
        req     = r;
        wren    = w;
        address = a;
        data    = d;
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        req = 0; wren = 0; address = 0; data = 0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if (busy_o[k] !== 1'b1 || q_o[k] !== 8'h00 ||
                qv_o[k] !== 1'b0 || ae_o[k] !== 1'b0)
                $display("FAIL reset dut%0d: got busy=%b q=%h qv=%b ae=%b want 1 00 0 0",
                         k, busy_o[k], q_o[k], qv_o[k], ae_o[k]);
            else pass++;
        end
    endtask

    task automatic test_init_sweep();
        int done [N];
        for (int k = 0; k < N; k++) done[k] = -1;
        @(negedge clock);
        reset_n = 1'b1;
        for (int e = 0; e < 210; e++) begin
            drive(e < 31, 1'b1, 8'd3, 8'hAA);
            for (int k = 0; k < N; k++) begin
                if (busy_o[k] === 1'b0 && done[k] < 0) done[k] = e + 1;
                total++;
                if (busy_o[k] !== (cyc[k] < DEP[k]))
                    $display("FAIL sweep_busy dut%0d e%0d: got %b want %b",
                             k, e, busy_o[k], cyc[k] < DEP[k]);
                else pass++;
                total++;
                if (qv_o[k] !== eqv[k] || ae_o[k] !== eae[k])
                    $display("FAIL sweep_flags dut%0d e%0d: got qv=%b ae=%b want %b %b",
                             k, e, qv_o[k], ae_o[k], eqv[k], eae[k]);
                else pass++;
            end
        end
        for (int k = 0; k < N; k++) begin
            total++;
            if (done[k] !== DEP[k])
                $display("FAIL busy_len dut%0d: got %0d want %0d", k, done[k], DEP[k]);
            else pass++;
        end
    endtask

    task automatic test_boot_read();
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 1'b0, 8'(a), 8'h00);
            for (int k = 0; k < 4; k++) begin
                total++;
                if (qv_o[k] !== 1'b1 || q_o[k] !== init_val(k, a))
                    $display("FAIL boot_read dut%0d a%0d: got qv=%b q=%h want 1 %h",
                             k, a, qv_o[k], q_o[k], init_val(k, a));
                else pass++;
            end
        end
    endtask

    task automatic test_write_modes();
        logic [7:0] hold;
        logic [7:0] want [3];
        logic       wantv [3];
        drive(1'b1, 1'b1, 8'd5, 8'h11);
        hold = eq[0];
        want  = '{hold, 8'h11, 8'h22};
        wantv = '{1'b0, 1'b1, 1'b1};
        drive(1'b1, 1'b1, 8'd5, 8'h22);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (q_o[k] !== want[k] || qv_o[k] !== wantv[k])
                $display("FAIL wmode dut%0d: got q=%h qv=%b want %h %b",
                         k, q_o[k], qv_o[k], want[k], wantv[k]);
            else pass++;
        end
        drive(1'b1, 1'b0, 8'd5, 8'h00);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (q_o[k] !== 8'h22 || qv_o[k] !== 1'b1)
                $display("FAIL wmode_rd dut%0d: got q=%h qv=%b want 22 1",
                         k, q_o[k], qv_o[k]);
            else pass++;
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 1'b1, 8'd250, 8'h55);
        for (int k = 0; k < N; k++) begin
            total++;
            if (ae_o[k] !== 1'b1)
                $display("FAIL oor_wr_err dut%0d: got %b want 1", k, ae_o[k]);
            else pass++;
        end
        total++;
        if (qv_o[3] !== 1'b0)
            $display("FAIL oor_wr_qv dut3: got %b want 0", qv_o[3]);
        else pass++;
        drive(1'b1, 1'b0, 8'd250, 8'h00);
        for (int k = 0; k < N; k++) begin
            total++;
            if (ae_o[k] !== 1'b1 || qv_o[k] !== 1'b1 || q_o[k] !== 8'h00)
                $display("FAIL oor_rd dut%0d: got ae=%b qv=%b q=%h want 1 1 00",
                         k, ae_o[k], qv_o[k], q_o[k]);
            else pass++;
        end
        drive(1'b1, 1'b0, 8'd199, 8'h00);
        total++;
        if (ae_o[3] !== 1'b0 || q_o[3] !== 8'h5A)
            $display("FAIL edge_199 dut3: got ae=%b q=%h want 0 5a", ae_o[3], q_o[3]);
        else pass++;
        drive(1'b1, 1'b0, 8'd200, 8'h00);
        total++;
        if (ae_o[3] !== 1'b1 || q_o[3] !== 8'h00)
            $display("FAIL edge_200 dut3: got ae=%b q=%h want 1 00", ae_o[3], q_o[3]);
        else pass++;
    endtask

    task automatic test_random();
        bit         w;
        logic [7:0] a;
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 1));
            a = w ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
            drive(1'($urandom_range(0, 3) != 0), w, a, 8'($urandom));
            for (int k = 0; k < N; k++) begin
                total++;
                if (qv_o[k] !== eqv[k] || ae_o[k] !== eae[k] || busy_o[k] !== 1'b0)
                    $display("FAIL rnd_flags dut%0d i%0d: got qv=%b ae=%b bz=%b want %b %b 0",
                             k, i, qv_o[k], ae_o[k], busy_o[k], eqv[k], eae[k]);
                else pass++;
                if (qk[k]) begin
                    total++;
                    if (q_o[k] !== eq[k])
                        $display("FAIL rnd_q dut%0d i%0d: got %h want %h",
                                 k, i, q_o[k], eq[k]);
                    else pass++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int done [N];
        for (int pass_no = 0; pass_no < 2; pass_no++) begin
            reset_n = 1'b0;
            model_reset();
            #1;
            for (int k = 0; k < N; k++) begin
                total++;
                if (busy_o[k] !== 1'b1 || q_o[k] !== 8'h00 ||
                    qv_o[k] !== 1'b0 || ae_o[k] !== 1'b0)
                    $display("FAIL mid_reset%0d dut%0d: got busy=%b q=%h qv=%b ae=%b",
                             pass_no, k, busy_o[k], q_o[k], qv_o[k], ae_o[k]);
                else pass++;
            end
            @(negedge clock);
            reset_n = 1'b1;
            if (pass_no == 0) begin
                for (int e = 0; e < 10; e++) drive(1'b0, 1'b0, 8'd0, 8'd0);
            end
        end
        for (int k = 0; k < N; k++) done[k] = -1;
        for (int e = 0; e < 205; e++) begin
            drive(1'b0, 1'b0, 8'd0, 8'd0);
            for (int k = 0; k < N; k++)
                if (busy_o[k] === 1'b0 && done[k] < 0) done[k] = e + 1;
        end
        for (int k = 0; k < N; k++) begin
            total++;
            if (done[k] !== DEP[k])
                $display("FAIL rst_busy_len dut%0d: got %0d want %0d", k, done[k], DEP[k]);
            else pass++;
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 3; a++) begin
            drive(1'b1, 1'b0, 8'(a), 8'h00);
            for (int k = 0; k < 4; k++) begin
                total++;
                if (qv_o[k] !== 1'b1 || q_o[k] !== init_val(k, a))
                    $display("FAIL b2b dut%0d a%0d: got qv=%b q=%h want 1 %h",
                             k, a, qv_o[k], q_o[k], init_val(k, a));
                else pass++;
            end
        end
        total++;
        if (ae_o[4] !== 1'b1 || q_o[4] !== 8'h00)
            $display("FAIL b2b_d1 dut4: got ae=%b q=%h want 1 00", ae_o[4], q_o[4]);
        else pass++;
        drive(1'b0, 1'b0, 8'd0, 8'h00);
        for (int k = 0; k < N; k++) begin
            total++;
            if (qv_o[k] !== 1'b0 || ae_o[k] !== 1'b0)
                $display("FAIL idle dut%0d: got qv=%b ae=%b want 0 0",
                         k, qv_o[k], ae_o[k]);
            else pass++;
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_boot_read();
        test_write_modes();
        test_out_of_range();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/ram_sp_boot.md
# ram_sp_boot

Parametrised single-port synchronous RAM for the 8-bit processor's unified program/data memory. It is the generalised successor of the fixed 31×8 preloaded RAM. Width, depth, read-during-write behaviour and initial contents are parameters. An internal init sequencer sweeps the array after every reset, loading either the shared boot image or a fill value, and reports `busy` until the memory is usable. It sits between the CPU core's memory port and nothing else; the core must hold off while `busy` is high.

## Interface
Parameters:
- `DW`, 8, data word width in bits.
- `AW`, 8, address width in bits.
- `DEPTH`, 256, number of words; legal range 1 to 2^AW.
- `INIT_MODE`, 1, selects the post-reset contents.
  - 0: every word is written with `FILL_VALUE`.
  - 1: word i is written with `BOOT_IMAGE[i]` for i < `BOOT_LEN`, and with `FILL_VALUE` otherwise.
- `FILL_VALUE`, 0, fill word (DW bits).
- `WRITE_MODE`, 0, sets what `q` does on a write.
  - 0: NO_CHANGE.
  - 1: READ_FIRST.
  - 2: WRITE_FIRST.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  access request, sampled on a rising edge.
- `wren`  in  1  1 = write, 0 = read; qualified by `req`.
- `address`  in  AW  word address.
- `data`  in  DW  write data.
- `q`  out  DW  registered read data.
- `q_valid`  out  1  one-cycle pulse: `q` was updated by the access accepted on the previous edge.
- `busy`  out  1  init sweep in progress; requests are ignored while high.
- `addr_err`  out  1  one-cycle pulse: the previous accepted access had `address` ≥ DEPTH.

## Operation
- The FSM has two states, INIT and READY.
- While `reset_n` = 0, all outputs and state take their reset values:
  - state = INIT, sweep counter = 0;
  - `busy` = 1, `q` = 0, `q_valid` = 0, `addr_err` = 0.
  - Array contents are not reset asynchronously.
- INIT:
  - Each rising edge writes one word at the sweep counter, then increments the counter.
  - The edge that writes word DEPTH-1 moves the FSM to READY.
  - `req` is ignored entirely: no write, no `q` change, no `q_valid`, no `addr_err`.
- READY, `req` = 1, `wren` = 0 (read): `q` ← mem[address], `q_valid` = 1.
- READY, `req` = 1, `wren` = 1 (write): mem[address] ← data. Output behaviour depends on `WRITE_MODE`:
  - NO_CHANGE: `q` holds and `q_valid` = 0.
  - READ_FIRST: `q` ← old mem[address] and `q_valid` = 1.
  - WRITE_FIRST: `q` ← data and `q_valid` = 1.
- Out-of-range access in READY (`address` ≥ DEPTH):
  - A write is suppressed; the array is unchanged.
  - A read returns `q` = 0 with `q_valid` = 1.
  - `addr_err` = 1 for one cycle.
  - For a write in NO_CHANGE mode, `addr_err` still pulses and `q_valid` stays 0.
- READY, `req` = 0: `q` holds its value; `q_valid` and `addr_err` are 0.
- Reset asserted mid-sweep or mid-operation: the FSM returns to INIT immediately and the sweep restarts from word 0 after release.

## Timing
- Read latency is 1 cycle: request at edge N, `q`/`q_valid` valid after edge N.
- Init takes exactly DEPTH cycles after reset release.
  - The first rising edge with `reset_n` = 1 writes word 0.
  - Edge DEPTH-1 writes the last word; `busy` is 0 after that edge.
  - The first accepted request is sampled at edge DEPTH.
- `busy` is registered and deasserts on the same edge as the INIT→READY transition.
- Back-to-back requests are accepted on every cycle in READY with no bubbles.
- A read immediately following a write to the same address returns the new data.
- DEPTH = 1: the sweep lasts 1 cycle, and every nonzero address is out of range.

## Structure
- Package `ram_pkg` contains:
  - the `write_mode_e` enum: NO_CHANGE = 0, READ_FIRST = 1, WRITE_FIRST = 2;
  - the `state_e` enum: INIT, READY;
  - `BOOT_LEN` and the `BOOT_IMAGE` constant array (8-bit words) holding the processor boot program.
- `ram_init_seq` is the one sub-module.
  - It contains the FSM and the sweep counter.
  - Outputs: `busy`, init write enable, init address, init data.
- The top level muxes the init port against the user port into a single write path on the array.

## Test plan
- Sweep and boot-image load:
  - Stimulus: INIT_MODE = 1, DEPTH = 32; release reset; count cycles, then read addresses 0..31.
  - Required: `busy` high for exactly 32 cycles; reads match `BOOT_IMAGE`, with `FILL_VALUE` beyond `BOOT_LEN`; each read has `q_valid` with 1-cycle latency.
- Requests during INIT:
  - Stimulus: write 0xAA to address 3 while `busy` = 1.
  - Required: no `q_valid`; after init, address 3 still holds its init value.
- Write modes (run each mode):
  - Stimulus: mem[5] = 0x11, then write 0x22 to address 5.
  - Required, NO_CHANGE: `q` unchanged, `q_valid` = 0.
  - Required, READ_FIRST: `q` = 0x11, `q_valid` = 1.
  - Required, WRITE_FIRST: `q` = 0x22, `q_valid` = 1.
  - Required, all modes: a subsequent read of address 5 returns 0x22.
- Out of range:
  - Stimulus: DEPTH = 200; write 0x55 to address 250, then read address 250.
  - Required: `addr_err` pulses on both accesses; read `q` = 0; array unchanged.
- Reset mid-operation:
  - Stimulus: assert `reset_n` = 0 at sweep count 10, then release.
  - Required: outputs go to reset values at once; `busy` then stays high a full DEPTH cycles.
  - Stimulus: back-to-back reads of addresses 0, 1, 2.
  - Required: `q_valid` high for 3 consecutive cycles with the correct data.
